// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Build option: define LSU_MISALIGN_SPLIT_EN to split misaligned half/word
// accesses into byte beats. When it is undefined, such accesses are rejected.
package dmem_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsuState_e;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    // Number of memory beats a legal request needs: aligned accesses go out
    // in one beat, misaligned ones go out one byte per beat.
    function automatic logic [2:0] beatCount(input logic [1:0] size, input logic misaligned);
        logic [2:0] n;
        n = 3'd1;
        if (misaligned) begin
            if (size == SZ_HALF) begin
                n = 3'd2;
            end else begin
                n = 3'd4;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational alignment helper for dmem_lsu.
// Always reports whether an incoming request is misaligned. With
// LSU_MISALIGN_SPLIT_EN defined it also selects the store byte for the
// current beat and extends the assembled load result.
module lsu_align
    import dmem_lsu_pkg::*;
(
    input  logic [1:0]  i_reqAddrLow,
    input  logic [1:0]  i_reqSize,
    output logic        o_misaligned
`ifdef LSU_MISALIGN_SPLIT_EN
    ,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_beat,
    input  logic [1:0]  i_size,
    input  logic        i_sext,
    input  logic [31:0] i_assembled,
    output logic [31:0] o_storeByte,
    output logic [31:0] o_loadResult
`endif
);

    // A half must start on an even byte, a word on a multiple of four.
    always_comb begin
        o_misaligned = 1'b0;
        if (i_reqSize == SZ_HALF) begin
            o_misaligned = i_reqAddrLow[0];
        end else if (i_reqSize == SZ_WORD) begin
            o_misaligned = (i_reqAddrLow != 2'b00);
        end
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Store beat k carries byte k of the store data in the low lane.
    always_comb begin
        o_storeByte = 32'd0;
        case (i_beat)
            2'd0:    o_storeByte[7:0] = i_wdata[7:0];
            2'd1:    o_storeByte[7:0] = i_wdata[15:8];
            2'd2:    o_storeByte[7:0] = i_wdata[23:16];
            default: o_storeByte[7:0] = i_wdata[31:24];
        endcase
    end

    // Halves are zero/sign extended from bit 15; words pass through untouched.
    always_comb begin
        o_loadResult = i_assembled;
        if (i_size == SZ_HALF) begin
            if (i_sext) begin
                o_loadResult = {{16{i_assembled[15]}}, i_assembled[15:0]};
            end else begin
                o_loadResult = {16'd0, i_assembled[15:0]};
            end
        end
    end
`endif

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator between the memory stage and the data memory.
// Accepts one request per handshake, drives 1-4 beats on the memory port,
// waits for good on each beat with a per-beat timeout and returns a single
// response. Build option LSU_MISALIGN_SPLIT_EN enables byte-beat splitting of
// misaligned half/word accesses; without it those requests are errors.
module dmem_lsu
    import dmem_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_sext,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_good,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_writeData,
    output logic        mem_memRead,
    output logic        mem_memWrite,
    output logic [1:0]  mem_maskMode,
    output logic        mem_sext,
    input  logic [31:0] mem_readData
);

    localparam logic [7:0] TIMEOUT_CYCLES = 8'(TIMEOUT);

    lsuState_e   r_state;
    lsuState_e   w_nextState;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_load;
    logic        r_sext;
    logic [7:0]  r_wait;
    logic [31:0] r_respRdata;
    logic        r_respErr;
    logic        w_reqMisaligned;
    logic        w_reqIllegal;
    logic        w_lastBeat;
    logic        w_waitExpired;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic        r_mis;
    logic [1:0]  r_beat;
    logic [31:0] r_buf;
    logic [31:0] w_assembled;
    logic [31:0] w_storeByte;
    logic [31:0] w_loadResult;
`endif

    lsu_align u_align (
        .i_reqAddrLow (req_addr[1:0]),
        .i_reqSize    (req_size),
        .o_misaligned (w_reqMisaligned)
`ifdef LSU_MISALIGN_SPLIT_EN
        ,
        .i_wdata      (r_wdata),
        .i_beat       (r_beat),
        .i_size       (r_size),
        .i_sext       (r_sext),
        .i_assembled  (w_assembled),
        .o_storeByte  (w_storeByte),
        .o_loadResult (w_loadResult)
`endif
    );

    // Classify the incoming request and the progress of the current beat.
    always_comb begin
        w_reqIllegal  = (req_load == req_store) || (req_size == SZ_ILLEGAL);
`ifdef LSU_MISALIGN_SPLIT_EN
        w_lastBeat    = !r_mis || ({1'b0, r_beat} == (beatCount(r_size, r_mis) - 3'd1));
`else
        w_reqIllegal  = w_reqIllegal || w_reqMisaligned;
        w_lastBeat    = 1'b1;
`endif
        w_waitExpired = (r_wait == TIMEOUT_CYCLES);
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    // Merge the byte returned by the current beat into its lane of the buffer.
    always_comb begin
        w_assembled = r_buf;
        case (r_beat)
            2'd0:    w_assembled[7:0]   = mem_readData[7:0];
            2'd1:    w_assembled[15:8]  = mem_readData[7:0];
            2'd2:    w_assembled[23:16] = mem_readData[7:0];
            default: w_assembled[31:24] = mem_readData[7:0];
        endcase
    end
`endif

    // Next-state logic; a completing beat wins over an expiring wait counter.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_nextState = w_reqIllegal ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_good) begin
                    if (w_lastBeat) begin
                        w_nextState = ST_RESP;
                    end
                end else if (w_waitExpired) begin
                    w_nextState = ST_RESP;
                end
            end
            ST_RESP: w_nextState = ST_IDLE;
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Drive the memory beat while in ACCESS and park every field at 0 otherwise.
    always_comb begin
        mem_valid     = 1'b0;
        mem_memRead   = 1'b0;
        mem_memWrite  = 1'b0;
        mem_addr      = 32'd0;
        mem_writeData = 32'd0;
        mem_maskMode  = SZ_BYTE;
        mem_sext      = 1'b0;
        if (r_state == ST_ACCESS) begin
            mem_valid     = 1'b1;
            mem_memRead   = r_load;
            mem_memWrite  = !r_load;
            mem_addr      = r_addr;
            mem_writeData = r_wdata;
            mem_maskMode  = r_size;
            mem_sext      = r_sext;
`ifdef LSU_MISALIGN_SPLIT_EN
            if (r_mis) begin
                mem_addr      = r_addr + {30'd0, r_beat};
                mem_writeData = w_storeByte;
                mem_maskMode  = SZ_BYTE;
                mem_sext      = 1'b0;
            end
`endif
        end
    end

    // Handshake and response outputs come straight from the state register.
    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = (r_state == ST_RESP);
        resp_rdata = r_respRdata;
        resp_err   = r_respErr;
    end

    // State register, latched request, wait counter and held response.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_size      <= SZ_BYTE;
            r_load      <= 1'b0;
            r_sext      <= 1'b0;
            r_wait      <= 8'd0;
            r_respRdata <= 32'd0;
            r_respErr   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            r_mis       <= 1'b0;
            r_beat      <= 2'd0;
            r_buf       <= 32'd0;
`endif
        end else begin
            r_state <= w_nextState;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_addr  <= req_addr;
                        r_wdata <= req_wdata;
                        r_size  <= req_size;
                        r_load  <= req_load;
                        r_sext  <= req_sext;
                        r_wait  <= 8'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_mis   <= w_reqMisaligned;
                        r_beat  <= 2'd0;
                        r_buf   <= 32'd0;
`endif
                        if (w_reqIllegal) begin
                            r_respErr   <= 1'b1;
                            r_respRdata <= 32'd0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (mem_good) begin
                        r_wait <= 8'd0;
`ifdef LSU_MISALIGN_SPLIT_EN
                        r_buf  <= w_assembled;
                        r_beat <= r_beat + 2'd1;
`endif
                        if (w_lastBeat) begin
                            r_respErr <= 1'b0;
                            if (!r_load) begin
                                r_respRdata <= 32'd0;
                            end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
                                r_respRdata <= r_mis ? w_loadResult : mem_readData;
`else
                                r_respRdata <= mem_readData;
`endif
                            end
                        end
                    end else if (w_waitExpired) begin
                        r_respErr   <= 1'b1;
                        r_respRdata <= 32'd0;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu with a byte-array memory model and a
// request-level reference model. Honours LSU_MISALIGN_SPLIT_EN.
module tb_dmem_lsu;

    localparam int TOUT = 4;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_load = 1'b0;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_sext = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_good;
    logic [31:0] mem_addr;
    logic [31:0] mem_writeData;
    logic        mem_memRead;
    logic        mem_memWrite;
    logic [1:0]  mem_maskMode;
    logic        mem_sext;
    logic [31:0] mem_readData;

    int checks = 0;
    int failures = 0;
    int devStall = 0;
    int devStallBeat = 0;
    int devWait;
    int devBeat;
    logic [31:0] lastRdata;

    logic [7:0] devMem [256];
    logic [7:0] refMem [256];
    logic [7:0] devA, devA1, devA2, devA3;

    always #5 clk = ~clk;

    dmem_lsu #(.TIMEOUT(TOUT)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_load      (req_load),
        .req_store     (req_store),
        .req_size      (req_size),
        .req_sext      (req_sext),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_err      (resp_err),
        .mem_valid     (mem_valid),
        .mem_good      (mem_good),
        .mem_addr      (mem_addr),
        .mem_writeData (mem_writeData),
        .mem_memRead   (mem_memRead),
        .mem_memWrite  (mem_memWrite),
        .mem_maskMode  (mem_maskMode),
        .mem_sext      (mem_sext),
        .mem_readData  (mem_readData)
    );

    function automatic logic [7:0] initByte(input int i);
        return 8'((i * 113 + 29) ^ (i / 8));
    endfunction

    // Memory device: combinational read and good, writes on a completed beat.
    assign devA  = mem_addr[7:0];
    assign devA1 = devA + 8'd1;
    assign devA2 = devA + 8'd2;
    assign devA3 = devA + 8'd3;
    assign mem_good = mem_valid && ((devBeat < devStallBeat) || (devWait >= devStall));

    always_comb begin
        case (mem_maskMode)
            2'b00:   mem_readData = mem_sext ? {{24{devMem[devA][7]}}, devMem[devA]} : {24'd0, devMem[devA]};
            2'b01:   mem_readData = mem_sext ? {{16{devMem[devA1][7]}}, devMem[devA1], devMem[devA]}
                                             : {16'd0, devMem[devA1], devMem[devA]};
            default: mem_readData = {devMem[devA3], devMem[devA2], devMem[devA1], devMem[devA]};
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) devMem[i] <= initByte(i);
            devWait <= 0;
            devBeat <= 0;
        end else begin
            if (mem_valid && mem_good && mem_memWrite) begin
                devMem[devA] <= mem_writeData[7:0];
                if (mem_maskMode != 2'b00) devMem[devA1] <= mem_writeData[15:8];
                if (mem_maskMode == 2'b10 || mem_maskMode == 2'b11) begin
                    devMem[devA2] <= mem_writeData[23:16];
                    devMem[devA3] <= mem_writeData[31:24];
                end
            end
            if (!mem_valid) begin
                devWait <= 0;
                devBeat <= 0;
            end else if (mem_good) begin
                devWait <= 0;
                devBeat <= devBeat + 1;
            end else begin
                devWait <= devWait + 1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic refInit();
        for (int i = 0; i < 256; i++) refMem[i] = initByte(i);
    endtask

    // Reset the DUT (and with it the memory device) from a post-edge point.
    task automatic doReset();
        reset = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        refInit();
    endtask

    // One request end to end, predicted from the request-level rules.
    task automatic applyStimulus(input string name, input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit isLoad, input bit isStore, input logic [1:0] size,
                                 input bit sext, input int stall, input int stallBeat);
        int nBytes, nBeats, expCycle, done, sk, written, cyc, obs, validCycles, respCyc;
        bit mis, legal, expErr, got, both, readyBusy;
        logic [31:0] expData, val, rd;
        logic [31:0] expAddr [4];
        logic [31:0] expWd [4];
        logic [1:0]  expMask;
        logic        expSx, er;
        logic [7:0]  idx;

        nBytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        mis    = (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
        legal  = (isLoad != isStore) && (size != 2'd3) && (SPLIT || !mis);
        nBeats = mis ? nBytes : 1;
        expMask = mis ? 2'd0 : size;
        expSx   = mis ? 1'b0 : sext;
        for (int k = 0; k < 4; k++) begin
            expAddr[k] = mis ? addr + 32'(k) : addr;
            expWd[k]   = mis ? {24'd0, wdata[8*k +: 8]} : wdata;
        end
        expCycle = 1;
        expErr   = !legal;
        done     = 0;
        if (legal) begin
            for (int k = 0; k < nBeats; k++) begin
                sk = (k < stallBeat) ? 0 : stall;
                if (sk > TOUT) begin
                    expErr = 1'b1;
                    expCycle += TOUT + 1;
                    break;
                end
                expCycle += sk + 1;
                done++;
            end
        end
        expData = 32'd0;
        if (legal && !expErr && isLoad) begin
            val = 32'd0;
            for (int i = 0; i < nBytes; i++) begin
                idx = 8'(addr + 32'(i));
                val = val | (32'(refMem[idx]) << (8 * i));
            end
            if (sext && nBytes < 4 && val[8*nBytes-1]) val = val | (32'hFFFFFFFF << (8 * nBytes));
            expData = val;
        end
        if (legal && isStore) begin
            written = !expErr ? nBytes : (mis ? done : 0);
            for (int i = 0; i < written; i++) begin
                idx = 8'(addr + 32'(i));
                refMem[idx] = wdata[8*i +: 8];
            end
        end

        devStall = stall;
        devStallBeat = stallBeat;
        req_valid = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        req_load  = isLoad;
        req_store = isStore;
        req_size  = size;
        req_sext  = sext;
        @(posedge clk); #1;

        cyc = 1; obs = 0; validCycles = 0; got = 0; both = 0; readyBusy = 0;
        respCyc = 0; rd = 32'd0; er = 1'b0;
        while (!got && cyc <= 64) begin
            req_valid = 1'($urandom_range(0, 1));
            req_addr  = $urandom;
            req_wdata = $urandom;
            req_load  = 1'($urandom_range(0, 1));
            req_store = !req_load;
            req_size  = 2'($urandom_range(0, 2));
            @(negedge clk);
            if (req_ready) readyBusy = 1;
            if (mem_memRead && mem_memWrite) both = 1;
            if (mem_valid) validCycles++;
            if (mem_valid && mem_good) begin
                if (obs < nBeats) begin
                    checkOutput({name, ".beatAddr"}, mem_addr, expAddr[obs]);
                    checkOutput({name, ".beatMask"}, 32'(mem_maskMode), 32'(expMask));
                    checkOutput({name, ".beatSext"}, 32'(mem_sext), 32'(expSx));
                    checkOutput({name, ".beatRead"}, 32'(mem_memRead), 32'(isLoad));
                    if (isStore) checkOutput({name, ".beatWdata"}, mem_writeData, expWd[obs]);
                end
                obs++;
            end
            if (resp_valid) begin
                got = 1;
                respCyc = cyc;
                rd = resp_rdata;
                er = resp_err;
                req_valid = 1'b0;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        req_valid = 1'b0;
        checkOutput({name, ".respSeen"}, 32'(got), 32'd1);
        if (!got) begin
            doReset();
            return;
        end
        checkOutput({name, ".respCycle"}, 32'(respCyc), 32'(expCycle));
        checkOutput({name, ".respErr"}, 32'(er), 32'(expErr));
        checkOutput({name, ".respData"}, rd, expData);
        checkOutput({name, ".beats"}, 32'(obs), 32'(done));
        checkOutput({name, ".validCycles"}, 32'(validCycles), legal ? 32'(expCycle - 1) : 32'd0);
        checkOutput({name, ".rdWrExcl"}, 32'(both), 32'd0);
        checkOutput({name, ".readyBusy"}, 32'(readyBusy), 32'd0);
        lastRdata = rd;

        @(posedge clk); #1;
        @(negedge clk);
        checkOutput({name, ".pulseEnd"}, 32'(resp_valid), 32'd0);
        checkOutput({name, ".readyIdle"}, 32'(req_ready), 32'd1);
        checkOutput({name, ".holdData"}, resp_rdata, rd);
        checkOutput({name, ".holdErr"}, 32'(resp_err), 32'(er));
        checkOutput({name, ".idleBus"}, {mem_valid, mem_memRead, mem_memWrite, mem_sext, mem_maskMode},
                    32'd0);
        checkOutput({name, ".idleAddr"}, mem_addr | mem_writeData, 32'd0);
        @(posedge clk); #1;
    endtask

    // Reset mid-ACCESS: the stalled beat is dropped along with its response.
    task automatic resetDuringAccess();
        bit respSeen;
        devStall = 100;
        devStallBeat = 0;
        req_valid = 1'b1;
        req_addr  = 32'h20;
        req_load  = 1'b1;
        req_store = 1'b0;
        req_size  = 2'd2;
        req_sext  = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("midReset.stalled", 32'(mem_valid), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midReset.memValid", 32'(mem_valid), 32'd0);
        checkOutput("midReset.ready", 32'(req_ready), 32'd1);
        checkOutput("midReset.respValid", 32'(resp_valid), 32'd0);
        checkOutput("midReset.respData", resp_rdata, 32'd0);
        respSeen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid || mem_valid) respSeen = 1;
        end
        checkOutput("midReset.quiet", 32'(respSeen), 32'd0);
        @(posedge clk); #1;
        refInit();
        devStall = 0;
    endtask

    initial begin
        int r, stall;
        logic [31:0] addr;
        logic [1:0]  size;
        bit ld, st;

        refInit();
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset.ready", 32'(req_ready), 32'd1);
        checkOutput("reset.resp", {resp_valid, resp_err}, 32'd0);
        checkOutput("reset.rdata", resp_rdata, 32'd0);
        checkOutput("reset.mem", {mem_valid, mem_memRead, mem_memWrite, mem_sext, mem_maskMode}, 32'd0);
        checkOutput("reset.memAddr", mem_addr | mem_writeData, 32'd0);
        @(posedge clk); #1;

        applyStimulus("sw10", 32'h10, 32'hDEADBEEF, 0, 1, 2'd2, 0, 0, 0);
        applyStimulus("lw10", 32'h10, 32'h0, 1, 0, 2'd2, 0, 0, 0);
        checkOutput("plan.lw10", lastRdata, 32'hDEADBEEF);
        applyStimulus("sb13", 32'h13, 32'h00000080, 0, 1, 2'd0, 0, 0, 0);
        applyStimulus("lb13", 32'h13, 32'h0, 1, 0, 2'd0, 1, 0, 0);
        checkOutput("plan.lb13", lastRdata, 32'hFFFFFF80);
        applyStimulus("lbu13", 32'h13, 32'h0, 1, 0, 2'd0, 0, 0, 0);
        checkOutput("plan.lbu13", lastRdata, 32'h00000080);
        applyStimulus("sh05", 32'h05, 32'h0000A55A, 0, 1, 2'd1, 0, 0, 0);
        applyStimulus("lh05", 32'h05, 32'h0, 1, 0, 2'd1, 1, 0, 0);
        checkOutput("plan.lh05", lastRdata, SPLIT ? 32'hFFFFA55A : 32'h0);
        applyStimulus("lw02", 32'h02, 32'h0, 1, 0, 2'd2, 0, 0, 0);
        applyStimulus("timeout", 32'h10, 32'h0, 1, 0, 2'd2, 0, TOUT + 1, 0);
        applyStimulus("stallMax", 32'h10, 32'h0, 1, 0, 2'd2, 0, TOUT, 0);
        applyStimulus("ldst", 32'h10, 32'h0, 1, 1, 2'd2, 0, 0, 0);
        applyStimulus("none", 32'h10, 32'h0, 0, 0, 2'd2, 0, 0, 0);
        applyStimulus("size3", 32'h10, 32'h0, 1, 0, 2'd3, 0, 0, 0);
        applyStimulus("swWrap", 32'hFFFFFFFE, 32'h11223344, 0, 1, 2'd2, 0, 1, 1);
        applyStimulus("lwWrap", 32'hFFFFFFFE, 32'h0, 1, 0, 2'd2, 0, 0, 0);
        applyStimulus("swPart", 32'h31, 32'hCAFEF00D, 0, 1, 2'd2, 0, TOUT + 2, 2);
        applyStimulus("lwPart", 32'h30, 32'h0, 1, 0, 2'd2, 0, 0, 0);

        resetDuringAccess();
        applyStimulus("afterReset", 32'h20, 32'h0, 1, 0, 2'd2, 0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 19);
            ld = (r >= 2) ? 1'($urandom_range(0, 1)) : (r == 0);
            st = (r >= 2) ? !ld : (r == 0);
            size = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            addr = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 63));
            stall = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(TOUT, TOUT + 2);
            applyStimulus("rand", addr, $urandom, ld, st, size, 1'($urandom_range(0, 1)), stall,
                          $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Load/store initiator that drives the data-memory port on behalf of the pipeline. Accepts one load or store per handshake and issues 1–4 beats on the memory port (valid/good, addr, writeData, memRead, memWrite, maskMode, sext). Waits for `good`, assembles and extends the read data, and returns a single response with an error flag. Sits between the execute/memory stage and the data memory.

## Interface
- TIMEOUT, 16: cycles a beat may wait for mem_good before aborting with error; range 1–255.
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_load  in  1  load request.
- req_store  in  1  store request.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_sext  in  1  sign-extend load result.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  32  load result; 0 for stores and errors.
- resp_err  out  1  request failed; valid with resp_valid.
- mem_valid  out  1  beat active.
- mem_good  in  1  memory completed beat this cycle.
- mem_addr  out  32  beat address.
- mem_writeData  out  32  beat store data.
- mem_memRead, mem_memWrite  out  1 each  beat direction; never both high.
- mem_maskMode  out  2  beat size, same encoding as req_size.
- mem_sext  out  1  memory-side sign extension.
- mem_readData  in  32  beat read data.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, latch the request. If illegal, go to RESP with err=1 and issue no beat. Illegal means: load and store both set, neither set, or size 11. Otherwise go to ACCESS with beat=0.
- Aligned requests use 1 beat. Aligned means byte; half with addr[0]=0; word with addr[1:0]=00. The beat uses mem_addr=req_addr, maskMode=req_size, mem_sext=req_sext and writeData=req_wdata. resp_rdata is mem_readData unchanged.
- Misaligned requests use N beats, N=2 for half and 4 for word (see Configuration).
  - Beat k: addr=req_addr+k (32-bit wrap), maskMode=00, mem_sext=0.
  - Store beat k: writeData[7:0] = req_wdata byte k; upper bits 0.
  - Load beat k: captures mem_readData[7:0] into byte lane k.
  - After the last beat the result is zero- or sign-extended from bit 15 (half) or used as-is (word) according to req_sext.
- ACCESS: mem_valid=1 and beat fields are held stable.
  - On mem_good=1 the beat completes at that edge: read data is captured and the wait counter is cleared. The LSU moves to the next beat, or to RESP after the last beat.
  - On mem_good=0 the beat is held unchanged. A held store beat may be re-written by memory each cycle; this is idempotent.
  - If the wait counter reaches TIMEOUT, go to RESP with err=1 and rdata=0. Bytes already stored stay written.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. resp_rdata and resp_err are held until the next response.
- Outside ACCESS: mem_valid, mem_memRead and mem_memWrite are 0; mem_addr, mem_writeData, maskMode and sext are 0.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all mem_* outputs 0, counters 0.
- The memory responds combinationally: mem_good is sampled in the same cycle mem_valid is driven.
- Aligned access with immediate good: accept at edge 0, ACCESS in cycle 1, resp_valid in cycle 2.
- Misaligned access with immediate good: resp_valid in cycle N+1.
- Illegal request: resp_valid in cycle 1; mem_valid never asserts.
- Timeout: resp_valid exactly TIMEOUT+1 cycles after the stalled beat first asserts.
- Reset asserted in any state: IDLE at the next edge and mem_valid=0. A pending response is dropped.
- req_valid during ACCESS or RESP is ignored; req_ready=0 there.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned half/word accesses are split into byte beats as above.
- LSU_MISALIGN_SPLIT_EN undefined: misaligned half/word requests are illegal. They return resp_err=1 in cycle 1 with no beat, and the byte-lane assembly logic is not built.

## Structure
- Package dmem_lsu_pkg: FSM state encoding, size constants (SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10), and the beat-count function.
- Sub-module lsu_align: combinational. It computes the misaligned predicate, extracts store bytes per beat, and zero/sign-extends the assembled load result.
- The FSM and counters stay in dmem_lsu.

## Test plan
- Aligned word store then load: store 0xDEADBEEF at 0x10, then lw 0x10. Expect two responses, rdata 0xDEADBEEF, err=0, each resp_valid in cycle 2.
- Byte load: byte at 0x13 = 0x80. lb 0x13 gives 0xFFFFFF80; lbu 0x13 gives 0x00000080.
- Misaligned with split enabled: sh 0xA55A at 0x05 gives beats at 0x05 (0x5A) and 0x06 (0xA5). lh 0x05 then gives 0xFFFFA55A, resp_valid in cycle 3.
- Misaligned with split disabled: lw 0x02 gives resp_err=1 in cycle 1 with mem_valid never high.
- Timeout and illegal requests:
  - Hold mem_good=0 with TIMEOUT=4: resp_err=1 and rdata=0 in the 5th cycle after the beat starts.
  - A request with req_load=req_store=1 gives err=1 with no beat.
- Reset mid-ACCESS: assert reset during a stalled beat. The next cycle shows IDLE, mem_valid=0, req_ready=1 and no resp_valid.
